// File: rtl/fibo_pkg.sv
// ---------------------------------------------------------------------------
// fibo_pkg
// Shared definitions for the Fibonacci (Zeckendorf) codec blocks.
//   CODE_W_DEF / BIN_W_DEF : default codeword and binary widths
//   state_t                : decoder control states
//   fib(n)                 : Fibonacci number F(n), with F(1) = F(2) = 1
//   MAX_CANON              : largest value that has a canonical CODE_W_DEF-bit code
// ---------------------------------------------------------------------------
package fibo_pkg;

    localparam int CODE_W_DEF = 16;
    localparam int BIN_W_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Iterative Fibonacci; usable as a constant function for widths and limits.
    function automatic int unsigned fib(input int n);
        int unsigned a;
        int unsigned b;
        int unsigned t;
        a = 0;
        b = 1;
        for (int i = 0; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    localparam int unsigned MAX_CANON = fib(CODE_W_DEF + 2) - 1;

endpackage

// File: rtl/fibo_decode_if.sv
// ---------------------------------------------------------------------------
// fibo_decode_if
// Request/result bundle between a codeword producer and fibo_decode.
//   en_decode    : request, sampled by the decoder only while idle
//   in_code      : Fibonacci codeword, captured with an accepted request
//   ack_input    : one-cycle pulse, request accepted
//   busy         : decoder is working; requests are ignored
//   done_decode  : one-cycle pulse, out_binary / err_noncanon valid
//   out_binary   : decoded value, held until the next result
//   err_noncanon : codeword had adjacent ones, held like out_binary
// master = producer side, slave = decoder side.
// ---------------------------------------------------------------------------
interface fibo_decode_if #(
    parameter int CODE_W = 16,
    parameter int BIN_W  = 16
);
    logic              en_decode;
    logic [CODE_W-1:0] in_code;
    logic              ack_input;
    logic              busy;
    logic              done_decode;
    logic [BIN_W-1:0]  out_binary;
    logic              err_noncanon;

    modport master (
        output en_decode, in_code,
        input  ack_input, busy, done_decode, out_binary, err_noncanon
    );

    modport slave (
        input  en_decode, in_code,
        output ack_input, busy, done_decode, out_binary, err_noncanon
    );
endinterface

// File: rtl/fibo_weight_gen.sv
// ---------------------------------------------------------------------------
// fibo_weight_gen
// Generates consecutive Fibonacci weights on the fly.
//   clk, rst : clock, synchronous active-high reset (clears both weights)
//   init     : load (wa, wb) = (1, 2), the weights of code bits 0 and 1
//   step     : advance (wa, wb) <= (wb, wa + wb)
//   wa       : weight of the code bit currently being processed
//   wb       : weight of the next code bit
// init has priority over step.
// ---------------------------------------------------------------------------
module fibo_weight_gen #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         init,
    input  logic         step,
    output logic [W-1:0] wa,
    output logic [W-1:0] wb
);

    always_ff @(posedge clk) begin
        if (rst) begin
            wa <= '0;
            wb <= '0;
        end else if (init) begin
            wa <= W'(1);
            wb <= W'(2);
        end else if (step) begin
            wa <= wb;
            wb <= wa + wb;
        end
    end

endmodule

// File: rtl/fibo_decode.sv
// ---------------------------------------------------------------------------
// fibo_decode
// Bit-serial Zeckendorf decoder: one code bit per clock, LSB first; bit i
// carries weight F(i+2). Result appears CODE_W+1 edges after the accepting
// edge; adjacent ones in the codeword raise err_noncanon, and the plain
// weighted sum is still returned.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset; aborts a decode in progress
//   bus  : fibo_decode_if.slave (request, handshake and result)
// ---------------------------------------------------------------------------
module fibo_decode
    import fibo_pkg::*;
#(
    parameter int CODE_W = CODE_W_DEF,
    parameter int BIN_W  = BIN_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    fibo_decode_if.slave   bus
);

    localparam int                CNT_W    = $clog2(CODE_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CODE_W - 1);

    state_t            state;
    state_t            state_next;

    logic [CODE_W-1:0] sreg;
    logic [BIN_W:0]    acc;
    logic [CNT_W-1:0]  cnt;
    logic              prev_bit;
    logic              err;
    logic [BIN_W-1:0]  out_binary;
    logic              err_noncanon;

    logic [BIN_W:0]    wa;
    logic [BIN_W:0]    unused_wb;

    logic              accept;
    logic              running;
    logic              last_bit;
    logic              bit_now;
    logic [BIN_W:0]    acc_next;
    logic              err_next;
    logic              unused_acc_msb;

    assign accept   = (state == IDLE) && bus.en_decode;
    assign running  = (state == RUN);
    assign last_bit = running && (cnt == LAST_CNT);
    assign bit_now  = sreg[0];

    // Values after folding in the current bit; also what gets published on the last bit.
    assign acc_next       = acc + (bit_now ? wa : '0);
    assign err_next       = err | (bit_now & prev_bit);
    assign unused_acc_msb = acc_next[BIN_W];

    fibo_weight_gen #(
        .W (BIN_W + 1)
    ) u_weight_gen (
        .clk  (clk),
        .rst  (rst),
        .init (accept),
        .step (running),
        .wa   (wa),
        .wb   (unused_wb)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: requests are only looked at in IDLE, DONE lasts one cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.en_decode) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST_CNT) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: capture on accept, one bit per RUN cycle, publish on the last bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg         <= '0;
            acc          <= '0;
            cnt          <= '0;
            prev_bit     <= 1'b0;
            err          <= 1'b0;
            out_binary   <= '0;
            err_noncanon <= 1'b0;
        end else begin
            if (accept) begin
                sreg     <= bus.in_code;
                acc      <= '0;
                cnt      <= '0;
                prev_bit <= 1'b0;
                err      <= 1'b0;
            end else if (running) begin
                acc      <= acc_next;
                err      <= err_next;
                prev_bit <= bit_now;
                sreg     <= sreg >> 1;
                cnt      <= cnt + CNT_W'(1);
            end

            if (last_bit) begin
                out_binary   <= acc_next[BIN_W-1:0];
                err_noncanon <= err_next;
            end
        end
    end

    // cnt is still 0 only in the first RUN cycle, i.e. right after the accepting edge.
    assign bus.ack_input    = running && (cnt == '0);
    assign bus.busy         = (state != IDLE);
    assign bus.done_decode  = (state == DONE);
    assign bus.out_binary   = out_binary;
    assign bus.err_noncanon = err_noncanon;

endmodule

// File: tb/tb_fibo_decode.sv
// ---------------------------------------------------------------------------
// tb_fibo_decode
// Directed bench for fibo_decode. Each issued request pushes its expected
// result into a queue; an independent monitor pops and compares whenever
// done_decode is seen.
// ---------------------------------------------------------------------------
module tb_fibo_decode;
    import fibo_pkg::*;

    localparam int CW = 16;
    localparam int BW = 16;

    typedef struct packed {
        logic [BW-1:0] bin;
        logic          err;
    } exp_t;

    logic clk;
    logic rst;

    fibo_decode_if #(.CODE_W(CW), .BIN_W(BW)) bus ();

    fibo_decode #(.CODE_W(CW), .BIN_W(BW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t exp_q[$];
    int   n_cmp;
    int   n_bad;
    int   n_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int unsigned act, input int unsigned req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst && bus.done_decode === 1'b1) begin
            n_done++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_binary", int'(bus.out_binary), int'(e.bin));
                check("err_noncanon", int'(bus.err_noncanon), int'(e.err));
            end
        end
    end

    // Reference encoder: greedy Zeckendorf representation, bit i weight F(i+2).
    function automatic logic [CW-1:0] zeck(input int unsigned val);
        logic [CW-1:0] c;
        int unsigned   v;
        c = '0;
        v = val;
        for (int i = CW - 1; i >= 0; i--) begin
            if (fib(i + 2) <= v) begin
                c[i] = 1'b1;
                v    = v - fib(i + 2);
            end
        end
        return c;
    endfunction

    // Wait for idle, issue one request, check ack and latency.
    task automatic decode(input logic [CW-1:0] code, input int unsigned exp_bin,
                          input logic exp_err, input bit chk_lat);
        int   guard;
        int   lat;
        exp_t e;
        @(posedge clk);
        #1;
        guard = 0;
        while (bus.busy === 1'b1 && guard < 40) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 40) check("idle_timeout", 1, 0);
        bus.en_decode = 1'b1;
        bus.in_code   = code;
        e.bin = BW'(exp_bin);
        e.err = exp_err;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        bus.en_decode = 1'b0;
        bus.in_code   = ~code;
        lat = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 1 && chk_lat) check("ack_input", int'(bus.ack_input), 1);
            if (bus.done_decode === 1'b1) begin
                lat = k;
                break;
            end
        end
        if (chk_lat) check("latency", lat, 17);
        else if (lat == 0) check("done_timeout", 1, 0);
    endtask

    int   last_c;
    int   cyc;
    int   vals[7];
    exp_t ve;

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        n_done = 0;
        bus.en_decode = 1'b0;
        bus.in_code   = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_busy", int'(bus.busy), 0);
        check("rst_ack", int'(bus.ack_input), 0);
        check("rst_done", int'(bus.done_decode), 0);
        check("rst_out", int'(bus.out_binary), 0);
        check("rst_err", int'(bus.err_noncanon), 0);

        // Directed vectors
        decode(16'h0014, 11, 1'b0, 1'b1);
        decode(16'hAAAA, 2583, 1'b0, 1'b1);
        decode(16'h0000, 0, 1'b0, 1'b1);
        decode(16'h0001, 1, 1'b0, 1'b1);
        decode(16'hFFFF, 4179, 1'b1, 1'b1);
        decode(16'h0003, 3, 1'b1, 1'b1);
        decode(16'h0005, 4, 1'b0, 1'b1);
        check("max_canon", int'(MAX_CANON), 2583);

        // Requests during RUN are ignored: pulses sampled at E5 and E16.
        @(posedge clk);
        #1;
        bus.en_decode = 1'b1;
        bus.in_code   = 16'h0014;
        ve.bin = 16'd11;
        ve.err = 1'b0;
        exp_q.push_back(ve);
        @(posedge clk);
        #1;
        bus.in_code = 16'h0001;
        for (int c = 1; c <= 24; c++) begin
            bus.en_decode = (c == 4 || c == 15);
            @(posedge clk);
            #1;
        end
        bus.en_decode = 1'b0;
        check("ignored_busy", int'(bus.busy), 0);
        check("ignored_out_held", int'(bus.out_binary), 11);

        // en_decode held high: one result every 18 cycles.
        for (int i = 0; i < 3; i++) begin
            ve.bin = 16'd4;
            ve.err = 1'b0;
            exp_q.push_back(ve);
        end
        @(posedge clk);
        #1;
        bus.en_decode = 1'b1;
        bus.in_code   = 16'h0005;
        cyc    = 0;
        last_c = -1;
        for (int d = 0; d < 3; d++) begin
            int got;
            got = 0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                cyc++;
                if (bus.done_decode === 1'b1) begin
                    got = 1;
                    break;
                end
            end
            if (got == 0) check("held_timeout", 1, 0);
            if (d == 2) bus.en_decode = 1'b0;
            if (last_c >= 0) check("held_period", cyc - last_c, 18);
            last_c = cyc;
        end
        repeat (25) @(posedge clk);
        #1;

        // Reset in the middle of RUN aborts without a result.
        bus.en_decode = 1'b1;
        bus.in_code   = 16'hAAAA;
        @(posedge clk);
        #1;
        bus.en_decode = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("abort_busy_before", int'(bus.busy), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_ack", int'(bus.ack_input), 0);
        check("abort_done", int'(bus.done_decode), 0);
        check("abort_out", int'(bus.out_binary), 0);
        check("abort_err", int'(bus.err_noncanon), 0);
        repeat (25) @(posedge clk);
        #1;
        decode(16'h0014, 11, 1'b0, 1'b1);

        // Encoder-to-decoder chain across the canonical range.
        vals = '{0, 1, 2, 3, 4, 1596, 2583};
        foreach (vals[i]) decode(zeck(vals[i]), vals[i], 1'b0, 1'b0);
        for (int v = 5; v < 2583; v += 37) decode(zeck(v), v, 1'b0, 1'b0);

        repeat (25) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        check("done_count_min", (n_done >= 20) ? 1 : 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
